// File: rtl/lib_rr_arbiter_lock.sv
// Round-robin arbiter with optional grant lock for multi-cycle transfers.
// Built from two carry-look-ahead programmable priority encoders.
module lib_rr_arbiter_lock_ppe #(
    parameter int N   = 16,
    parameter int LAH = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    if (LAH == 0) begin : g_ripple
        always_comb begin
            logic c;
            c   = 1'b1;
            gnt = '0;
            for (int i = 0; i < N; i++) begin
                gnt[i] = req[i] & c;
                c      = c & ~req[i];
            end
        end
    end else begin : g_lah
        localparam int G = N / LAH;
        // group carry skips whole groups without rippling through them
        always_comb begin
            logic gc;
            logic lc;
            gc  = 1'b1;
            lc  = 1'b1;
            gnt = '0;
            for (int g = 0; g < G; g++) begin
                lc = gc;
                for (int j = 0; j < LAH; j++) begin
                    gnt[g*LAH+j] = req[g*LAH+j] & lc;
                    lc           = lc & ~req[g*LAH+j];
                end
                gc = gc & ~(|req[g*LAH +: LAH]);
            end
        end
    end

endmodule

module lib_rr_arbiter_lock #(
    parameter int N       = 16,
    parameter int LAH     = 4,
    parameter bit HOLD_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_request,
    input  logic         i_hold,
    input  logic         i_accept,
    output logic [N-1:0] o_grant,
    output logic         o_anyGnt,
    output logic         o_locked,
    output logic [N-1:0] o_priority
);

    if (N < 2) begin : g_bad_n
        $error("lib_rr_arbiter_lock: N must be >= 2");
    end
    if (LAH != 0 && (N % LAH) != 0) begin : g_bad_lah
        $error("lib_rr_arbiter_lock: N must be a multiple of LAH");
    end

    typedef enum logic {ARB, LOCKED} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pri_q, pri_d;
    logic [N-1:0] lock_q, lock_d;

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] gnt_hi;
    logic [N-1:0] gnt_lo;
    logic [N-1:0] arb_gnt;
    logic         any_req;
    logic         owner_req;
    logic         hold_eff;

    assign hold_eff = i_hold & HOLD_EN;

    // thermometer of bits at or above the priority pointer
    always_comb begin
        logic m;
        m    = 1'b0;
        mask = '0;
        for (int i = 0; i < N; i++) begin
            m       = m | pri_q[i];
            mask[i] = m;
        end
    end

    assign req_hi = i_request & mask;

    lib_rr_arbiter_lock_ppe #(.N(N), .LAH(LAH)) u_ppe_hi (
        .req (req_hi),
        .gnt (gnt_hi)
    );

    lib_rr_arbiter_lock_ppe #(.N(N), .LAH(LAH)) u_ppe_lo (
        .req (i_request),
        .gnt (gnt_lo)
    );

    assign arb_gnt   = (|req_hi) ? gnt_hi : gnt_lo;
    assign any_req   = |i_request;
    assign owner_req = (state_q == LOCKED) && (|(lock_q & i_request));

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        pri_d    = pri_q;
        o_grant  = arb_gnt;
        o_anyGnt = any_req;
        if (owner_req) begin
            o_grant  = lock_q;
            o_anyGnt = 1'b1;
            if (i_accept && !hold_eff) begin
                state_d = ARB;
                lock_d  = '0;
            end
        end else begin
            // a dropped owner falls straight into arbitration, no bubble
            state_d = ARB;
            lock_d  = '0;
            if (i_accept && any_req) begin
                pri_d = {arb_gnt[N-2:0], arb_gnt[N-1]};
                if (hold_eff) begin
                    lock_d  = arb_gnt;
                    state_d = LOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            pri_q   <= N'(1);
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            lock_q  <= lock_d;
        end
    end

    assign o_locked   = (state_q == LOCKED);
    assign o_priority = pri_q;

endmodule

// File: doc/lib_rr_arbiter_lock.md
Name: lib_rr_arbiter_lock

Overview:
- Sequential round-robin arbiter built around the fast programmable priority encoder (PPE with carry-look-ahead).
- Holds a registered one-hot priority pointer that rotates past each accepted grant, so requesters are served fairly.
- Optional grant lock keeps one requester granted across a multi-cycle transfer, such as a multi-flit packet.
- Used by switch/router output ports in place of a purely combinational PPE.

Parameters:
N, 16, number of requesters; N >= 2.
LAH, 4, look-ahead group size of the internal PPE; 0 selects the plain ripple PPE; when non-zero, N % LAH must be 0 (elaboration error otherwise).
HOLD_EN, 1, 1 enables the lock feature; 0 ties i_hold low internally, so the block never leaves ARB.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
i_request  input  N  request vector, one bit per requester.
i_hold  input  1  qualifies an accepted grant: 1 = lock the granted requester.
i_accept  input  1  downstream has consumed the current grant this cycle.
o_grant  output  N  one-hot grant, or zero; combinational from inputs and state.
o_anyGnt  output  1  high when o_grant is non-zero.
o_locked  output  1  high when the FSM is in LOCKED (registered).
o_priority  output  N  current one-hot priority pointer (registered; for debug and verification).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: pri_q = one-hot bit 0; lock_q = 0; state = ARB.
  - o_locked = 0 and o_priority = 1 during and after reset.
  - o_grant and o_anyGnt are combinational and follow the ARB rules below with pri_q = bit 0.
- Arbitration function arb(req, pri):
  - Returns the first set bit of req scanning upward from the index of pri's set bit, wrapping N-1 -> 0.
  - Returns zero when req == 0.
  - Implemented as two PPEs (priority-qualified and zero-priority) plus a select mux.
  - Any-grant for this function is |req.
- States: ARB, LOCKED.
- ARB:
  - Outputs: o_grant = arb(i_request, pri_q); o_anyGnt = |i_request.
  - Update only on (i_accept & o_anyGnt):
    - pri_q <= rotl(o_grant, 1), where bit N-1 wraps to bit 0.
    - If i_hold, then lock_q <= o_grant and state <= LOCKED.
  - i_accept with o_anyGnt = 0 is ignored; no state change.
  - No i_accept: pri_q holds, and o_grant stays stable while i_request is unchanged.
- LOCKED, owner still requesting ((lock_q & i_request) != 0):
  - Outputs: o_grant = lock_q; o_anyGnt = 1.
  - Other requests are ignored.
  - pri_q is not modified; it already points one past the owner.
  - On i_accept & ~i_hold: state <= ARB and lock_q <= 0.
  - On i_accept & i_hold: stay LOCKED.
  - No i_accept: stay LOCKED.
- LOCKED, owner request dropped:
  - The block behaves exactly as ARB in that same cycle (outputs and update rules).
  - The next state is taken from the ARB rules, so it can re-lock onto a new owner; otherwise it returns to ARB.
  - No idle bubble cycle is inserted.
- o_grant invariants:
  - Always one-hot or zero.
  - Never asserts a bit whose i_request bit is 0.
- Latency: grant is zero-cycle from i_request; pointer and state changes take effect the cycle after the accepting edge.
- Reset mid-lock: the lock is abandoned immediately (asynchronously) and arbitration restarts from bit 0.
- Fairness: with all N requesting and accept every cycle (hold = 0), each requester is granted exactly once per N cycles.

Test Plan:
1. N=4, LAH=2; after reset, i_request=4'b1111, i_accept=1, i_hold=0 for 5 cycles -> o_grant sequence 0001, 0010, 0100, 1000, 0001; o_priority after cycle 4 = 0001 (wrap).
2. After reset, i_request=4'b1000, accept=1 -> o_grant=1000 and o_anyGnt=1; next cycle o_priority=0001 (wrap from bit 3).
3. i_request=0 with i_accept=1 for 2 cycles -> o_grant=0, o_anyGnt=0, o_priority unchanged at 0001, o_locked=0.
4. i_request=1111; accept+hold on grant 0001 -> o_locked=1.
   - Next 3 cycles: o_grant=0001 despite other requests.
   - Then accept with hold=0 -> o_locked=0, o_priority=0010; next o_grant=0010.
5. Locked on 0010 (o_priority=0100); i_request changes to 1001 -> same cycle o_grant=1000, o_anyGnt=1; without accept, o_locked=0 on the next cycle.
6. Locked on 0100; assert reset mid-cycle -> o_locked=0 and o_priority=0001 immediately; with i_request=0110, o_grant=0010. Repeat scenario 1 with LAH=0 and N=8 (HOLD_EN=0, i_hold=1) -> 8-cycle rotation, o_locked stays 0.
